risc16_regfile_sb: RTL and testbench

Parametrised register file with a per-register busy scoreboard and write-to-read bypass for the pipelined RiSC-16 core. It supports two combinational read ports and one synchronous write port. Issue logic reserves a destination register; the write-back stage releases it. Decode stalls on a register's busy flag instead of computing hazards itself. Register 0 reads as zero and is never busy.

---
 rtl/risc16_regfile_sb.sv | 50 +++++
 tb/tb_risc16_regfile_sb.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/risc16_regfile_sb.sv
// risc16_regfile_sb: register file with per-register busy scoreboard and write-to-read bypass
module risc16_regfile_sb #(
    parameter int WIDTH = 16,
    parameter int NREGS = 8,
    localparam int AW = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AW-1:0]    ra1,
    input  logic [AW-1:0]    ra2,
    output logic [WIDTH-1:0] rd1,
    output logic [WIDTH-1:0] rd2,
    output logic             busy1,
    output logic             busy2,
    input  logic             we,
    input  logic [AW-1:0]    wa,
    input  logic [WIDTH-1:0] wd,
    input  logic             rsv_en,
    input  logic [AW-1:0]    rsv_addr,
    output logic             rsv_ready,
    input  logic             flush
);
    logic [WIDTH-1:0] r_data [NREGS];
    logic [NREGS-1:0] r_busy;
    logic             w_wr;
    logic             w_rsv;
    always_comb begin
        w_wr      = we && wa != '0;
        rd1       = ra1 == '0 ? '0 : (we && wa == ra1) ? wd : r_data[ra1];
        rd2       = ra2 == '0 ? '0 : (we && wa == ra2) ? wd : r_data[ra2];
        busy1     = ra1 != '0 && r_busy[ra1] && !(we && wa == ra1);
        busy2     = ra2 != '0 && r_busy[ra2] && !(we && wa == ra2);
        rsv_ready = rsv_addr == '0 || !r_busy[rsv_addr] || (we && wa == rsv_addr);
        w_rsv     = rsv_en && rsv_ready && rsv_addr != '0;
    end
    // The reservation is applied after the release so a same-cycle reserve wins
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) r_data[i] <= '0;
            r_busy <= '0;
        end else begin
            if (w_wr) r_data[wa] <= wd;
            if (flush) r_busy <= '0;
            else begin
                if (w_wr) r_busy[wa] <= 1'b0;
                if (w_rsv) r_busy[rsv_addr] <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_risc16_regfile_sb.sv
// tb_risc16_regfile_sb: scoreboard bench for the register file, default and 32x16 instances
module tb_risc16_regfile_sb;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  ra1 = '0, ra2 = '0, wa = '0, rsv_addr = '0;
    logic [15:0] rd1, rd2, wd = '0;
    logic        busy1, busy2, we = 1'b0, rsv_en = 1'b0, rsv_ready, flush = 1'b0;
    logic [3:0]  x_ra1 = '0, x_ra2 = '0, x_wa = '0, x_rsv_addr = '0;
    logic [31:0] x_rd1, x_rd2, x_wd = '0;
    logic        x_busy1, x_busy2, x_we = 1'b0, x_rsv_en = 1'b0, x_rsv_ready;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] val;
    } exp_t;
    exp_t q[$];
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    risc16_regfile_sb dut (
        .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .busy1(busy1), .busy2(busy2), .we(we), .wa(wa), .wd(wd),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ready(rsv_ready), .flush(flush)
    );

    risc16_regfile_sb #(.WIDTH(32), .NREGS(16)) dut_x (
        .clk(clk), .rst(rst), .ra1(x_ra1), .ra2(x_ra2), .rd1(x_rd1), .rd2(x_rd2),
        .busy1(x_busy1), .busy2(x_busy2), .we(x_we), .wa(x_wa), .wd(x_wd),
        .rsv_en(x_rsv_en), .rsv_addr(x_rsv_addr), .rsv_ready(x_rsv_ready), .flush(1'b0)
    );

    // Monitor: outputs are stable mid-cycle, so every queued expectation is checked on negedge
    always @(negedge clk) begin
        logic [31:0] act;
        exp_t e;
        while (q.size() != 0) begin
            e = q.pop_front();
            case (e.sel)
                0: act = {16'h0, rd1};
                1: act = {16'h0, rd2};
                2: act = {31'h0, busy1};
                3: act = {31'h0, busy2};
                4: act = {31'h0, rsv_ready};
                5: act = x_rd1;
                6: act = x_rd2;
                7: act = {31'h0, x_busy1};
                8: act = {31'h0, x_busy2};
                default: act = {31'h0, x_rsv_ready};
            endcase
            n_chk++;
            if (act !== e.val) begin
                n_fail++;
                $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, act, e.val);
            end
        end
    end

    task automatic expect_v(input string name, input int sel, input logic [31:0] val);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.val  = val;
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        step();
        rst = 1'b0;
        for (int a = 0; a < 8; a++) begin
            ra1 = 3'(a);
            ra2 = 3'(a);
            rsv_addr = 3'(a);
            expect_v($sformatf("reset rd1 r%0d", a), 0, 0);
            expect_v($sformatf("reset rd2 r%0d", a), 1, 0);
            expect_v($sformatf("reset busy1 r%0d", a), 2, 0);
            expect_v($sformatf("reset busy2 r%0d", a), 3, 0);
            expect_v($sformatf("reset ready r%0d", a), 4, 1);
            step();
        end
        // r0 is hardwired to zero, even through the bypass
        we = 1'b1; wa = 3'd0; wd = 16'hBEEF; ra1 = 3'd0;
        expect_v("r0 write bypass", 0, 0);
        step();
        we = 1'b0;
        expect_v("r0 after write", 0, 0);
        step();
        we = 1'b1; wa = 3'd3; wd = 16'h1234; ra1 = 3'd3;
        expect_v("bypass rd1 r3", 0, 32'h1234);
        expect_v("bypass busy1 r3", 2, 0);
        step();
        we = 1'b0;
        expect_v("stored rd1 r3", 0, 32'h1234);
        step();
        rsv_en = 1'b1; rsv_addr = 3'd5;
        expect_v("ready before rsv r5", 4, 1);
        step();
        rsv_en = 1'b0; ra2 = 3'd5;
        expect_v("busy2 r5 reserved", 3, 1);
        expect_v("ready r5 reserved", 4, 0);
        step();
        we = 1'b1; wa = 3'd5; wd = 16'h00AA;
        expect_v("busy2 r5 during wb", 3, 0);
        expect_v("rd2 r5 during wb", 1, 32'h00AA);
        expect_v("ready r5 during wb", 4, 1);
        step();
        we = 1'b0;
        expect_v("busy2 r5 after wb", 3, 0);
        expect_v("rd2 r5 after wb", 1, 32'h00AA);
        expect_v("ready r5 after wb", 4, 1);
        step();
        rsv_en = 1'b1; rsv_addr = 3'd2;
        step();
        we = 1'b1; wa = 3'd2; wd = 16'h5555; ra1 = 3'd2;
        expect_v("conflict ready r2", 4, 1);
        expect_v("conflict busy1 r2", 2, 0);
        expect_v("conflict rd1 r2", 0, 32'h5555);
        step();
        we = 1'b0; rsv_en = 1'b0;
        expect_v("post conflict busy1 r2", 2, 1);
        expect_v("post conflict rd1 r2", 0, 32'h5555);
        expect_v("post conflict ready r2", 4, 0);
        step();
        rsv_en = 1'b1;
        for (int a = 1; a < 8; a += 3) begin
            rsv_addr = 3'(a);
            step();
        end
        rsv_en = 1'b0; ra1 = 3'd7; ra2 = 3'd4;
        expect_v("busy1 r7 reserved", 2, 1);
        expect_v("busy2 r4 reserved", 3, 1);
        step();
        // Flush with a same-cycle write (kept) and reservation (dropped)
        flush = 1'b1; we = 1'b1; wa = 3'd3; wd = 16'h3333; rsv_en = 1'b1; rsv_addr = 3'd6;
        step();
        flush = 1'b0; we = 1'b0; rsv_en = 1'b0;
        for (int a = 0; a < 8; a++) begin
            ra1 = 3'(a);
            ra2 = 3'(a);
            expect_v($sformatf("flush busy1 r%0d", a), 2, 0);
            expect_v($sformatf("flush busy2 r%0d", a), 3, 0);
            step();
        end
        ra1 = 3'd5; ra2 = 3'd3; rsv_addr = 3'd6;
        expect_v("flush keeps r5", 0, 32'h00AA);
        expect_v("flush write r3", 1, 32'h3333);
        expect_v("flush drops rsv r6", 4, 1);
        step();
        ra1 = 3'd2;
        expect_v("flush keeps r2", 0, 32'h5555);
        step();
        rst = 1'b1; we = 1'b1; wa = 3'd6; wd = 16'hFFFF; rsv_en = 1'b1; rsv_addr = 3'd1;
        step();
        rst = 1'b0; we = 1'b0; rsv_en = 1'b0; ra1 = 3'd6; ra2 = 3'd5;
        expect_v("reset blocks write r6", 0, 0);
        expect_v("reset clears r5", 1, 0);
        expect_v("reset blocks rsv r1", 4, 1);
        step();
        x_we = 1'b1; x_wa = 4'd15; x_wd = 32'hDEADBEEF;
        step();
        x_we = 1'b0; x_ra1 = 4'd15; x_ra2 = 4'd15;
        expect_v("wide rd1 r15", 5, 32'hDEADBEEF);
        expect_v("wide rd2 r15", 6, 32'hDEADBEEF);
        expect_v("wide busy1 r15 idle", 7, 0);
        step();
        x_rsv_en = 1'b1; x_rsv_addr = 4'd15;
        step();
        x_rsv_en = 1'b0;
        expect_v("wide busy1 r15", 7, 1);
        expect_v("wide busy2 r15", 8, 1);
        expect_v("wide ready r15", 9, 0);
        step();
        for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
